// File: rtl/round_robin_ponderado_param.sv
// round_robin_ponderado_param: weighted round-robin / strict-priority FIFO pop arbiter with occupancy-limited bursts
module round_robin_ponderado_param #(
    parameter int QUEUE_QUANTITY = 4,
    parameter int MAX_WEIGHT     = 64,
    parameter int BUF_WIDTH      = 3,
    localparam int WB = $clog2(MAX_WEIGHT),
    localparam int CW = BUF_WIDTH + 1,
    localparam int SB = $clog2(QUEUE_QUANTITY)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enb,
    input  logic                         mode,
    input  logic [QUEUE_QUANTITY*WB-1:0] pesos,
    input  logic [QUEUE_QUANTITY-1:0]    buf_empty,
    input  logic [QUEUE_QUANTITY*CW-1:0] fifo_counter,
    input  logic                         dest_full,
    output logic [SB-1:0]                selector,
    output logic                         selector_enb,
    output logic                         burst_last
);
    localparam int LW = (WB > CW) ? WB : CW;

    logic [SB-1:0]             cur_q, cur_d, sel_q, sel_d, rr_idx, pr_idx;
    logic [WB-1:0]             credit_q, credit_d;
    logic                      enb_q, enb_d, last_q, last_d, rr_found, pr_found;
    logic [QUEUE_QUANTITY-1:0] eligible;
    logic [CW-1:0]             occ  [QUEUE_QUANTITY];
    logic [WB-1:0]             load [QUEUE_QUANTITY];

    // Eligibility and burst length: a burst never exceeds the weight nor the FIFO fill (min 1)
    always_comb begin
        for (int i = 0; i < QUEUE_QUANTITY; i++) begin
            eligible[i] = !buf_empty[i] && (pesos[i*WB +: WB] != '0);
            occ[i]      = (fifo_counter[i*CW +: CW] == '0) ? CW'(1) : fifo_counter[i*CW +: CW];
            load[i]     = (LW'(pesos[i*WB +: WB]) < LW'(occ[i])) ? pesos[i*WB +: WB] : WB'(occ[i]);
        end
    end

    // Circular search from cur+1 (cur last) and lowest-index search; later loop passes win
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = cur_q;
        pr_found = 1'b0;
        pr_idx   = '0;
        for (int k = QUEUE_QUANTITY; k >= 1; k--) begin
            if (eligible[(int'(cur_q) + k) % QUEUE_QUANTITY]) begin
                rr_found = 1'b1;
                rr_idx   = SB'((int'(cur_q) + k) % QUEUE_QUANTITY);
            end
        end
        for (int i = QUEUE_QUANTITY - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                pr_found = 1'b1;
                pr_idx   = SB'(i);
            end
        end
    end

    // Next grant: stall holds everything, priority mode drops credit, weighted mode holds or switches
    always_comb begin
        cur_d    = cur_q;
        credit_d = credit_q;
        sel_d    = sel_q;
        enb_d    = 1'b0;
        last_d   = 1'b0;
        if (enb && !dest_full) begin
            if (mode) begin
                credit_d = '0;
                if (pr_found) begin
                    cur_d  = pr_idx;
                    sel_d  = pr_idx;
                    enb_d  = 1'b1;
                    last_d = 1'b1;
                end
            end else if (credit_q != '0 && eligible[cur_q]) begin
                credit_d = credit_q - 1'b1;
                sel_d    = cur_q;
                enb_d    = 1'b1;
                last_d   = (credit_q == WB'(1));
            end else if (rr_found) begin
                cur_d    = rr_idx;
                sel_d    = rr_idx;
                enb_d    = 1'b1;
                credit_d = load[rr_idx] - 1'b1;
                last_d   = (load[rr_idx] == WB'(1));
            end else begin
                credit_d = '0;
            end
        end
    end

    // Arbitration state and registered grant outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_q    <= '0;
            credit_q <= '0;
            sel_q    <= '0;
            enb_q    <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            cur_q    <= cur_d;
            credit_q <= credit_d;
            sel_q    <= sel_d;
            enb_q    <= enb_d;
            last_q   <= last_d;
        end
    end

    assign selector     = sel_q;
    assign selector_enb = enb_q;
    assign burst_last   = last_q;
endmodule

// File: tb/tb_round_robin_ponderado_param.sv
// tb_round_robin_ponderado_param: scoreboard bench for the weighted round-robin arbiter
module tb_round_robin_ponderado_param;
    logic        clk = 1'b0;
    logic        rst, enb, mode, dest_full;
    logic [23:0] pesos;
    logic [3:0]  buf_empty;
    logic [15:0] fifo_counter;
    logic [1:0]  selector;
    logic        selector_enb, burst_last;

    typedef struct {
        logic [1:0] sel;
        logic       enb;
        logic       last;
    } exp_t;

    exp_t  sb[$];
    exp_t  e;
    int    checks = 0;
    int    passes = 0;
    string tname;

    round_robin_ponderado_param #(.QUEUE_QUANTITY(4), .MAX_WEIGHT(64), .BUF_WIDTH(3)) dut (
        .clk(clk), .rst(rst), .enb(enb), .mode(mode), .pesos(pesos),
        .buf_empty(buf_empty), .fifo_counter(fifo_counter), .dest_full(dest_full),
        .selector(selector), .selector_enb(selector_enb), .burst_last(burst_last)
    );

    always #5 clk = ~clk;

    function automatic void push_grant(int q, bit last);
        exp_t x;
        x.sel  = 2'(q);
        x.enb  = 1'b1;
        x.last = last;
        sb.push_back(x);
    endfunction

    function automatic void push_run(int q, int n);
        for (int i = 0; i < n; i++) push_grant(q, i == n - 1);
    endfunction

    function automatic void push_idle(int q, int n);
        exp_t x;
        x.sel  = 2'(q);
        x.enb  = 1'b0;
        x.last = 1'b0;
        for (int i = 0; i < n; i++) sb.push_back(x);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tname = "reset";
        rst = 1'b1; enb = 1'b1; mode = 1'b0; dest_full = 1'b0;
        pesos = {6'd6, 6'd3, 6'd2, 6'd1};
        buf_empty = 4'b0000;
        fifo_counter = {4'd8, 4'd8, 4'd8, 4'd8};
        push_idle(0, 2);
        while (sb.size() > 0) begin
            tick(); e = sb.pop_front(); checks++;
            if ({selector, selector_enb, burst_last} !== {e.sel, e.enb, e.last})
                $display("FAIL %s #%0d: got sel=%0d enb=%0b last=%0b, expected sel=%0d enb=%0b last=%0b", tname, checks, selector, selector_enb, burst_last, e.sel, e.enb, e.last);
            else passes++;
        end
        rst = 1'b0;
    endtask

    task automatic test_weighted();
        tname = "weighted";
        for (int r = 0; r < 2; r++) begin
            push_run(1, 2); push_run(2, 3); push_run(3, 6); push_run(0, 1);
        end
        while (sb.size() > 0) begin
            tick(); e = sb.pop_front(); checks++;
            if ({selector, selector_enb, burst_last} !== {e.sel, e.enb, e.last})
                $display("FAIL %s #%0d: got sel=%0d enb=%0b last=%0b, expected sel=%0d enb=%0b last=%0b", tname, checks, selector, selector_enb, burst_last, e.sel, e.enb, e.last);
            else passes++;
        end
    endtask

    task automatic test_zero_weight();
        tname = "zero_weight";
        pesos[6 +: 6] = 6'd0;
        for (int r = 0; r < 2; r++) begin
            push_run(2, 3); push_run(3, 6); push_run(0, 1);
        end
        while (sb.size() > 0) begin
            tick(); e = sb.pop_front(); checks++;
            if ({selector, selector_enb, burst_last} !== {e.sel, e.enb, e.last})
                $display("FAIL %s #%0d: got sel=%0d enb=%0b last=%0b, expected sel=%0d enb=%0b last=%0b", tname, checks, selector, selector_enb, burst_last, e.sel, e.enb, e.last);
            else passes++;
        end
        pesos[6 +: 6] = 6'd2;
    endtask

    task automatic test_occupancy();
        tname = "occupancy";
        fifo_counter[8 +: 4] = 4'd1;
        push_run(1, 2); push_run(2, 1); push_run(3, 6); push_run(0, 1);
        while (sb.size() > 0) begin
            tick(); e = sb.pop_front(); checks++;
            if ({selector, selector_enb, burst_last} !== {e.sel, e.enb, e.last})
                $display("FAIL %s #%0d: got sel=%0d enb=%0b last=%0b, expected sel=%0d enb=%0b last=%0b", tname, checks, selector, selector_enb, burst_last, e.sel, e.enb, e.last);
            else passes++;
        end
        fifo_counter[8 +: 4] = 4'd8;
    endtask

    task automatic test_enable_hold();
        tname = "enable_hold";
        push_run(1, 2); push_grant(2, 1'b0);
        while (sb.size() > 0) begin
            tick(); e = sb.pop_front(); checks++;
            if ({selector, selector_enb, burst_last} !== {e.sel, e.enb, e.last})
                $display("FAIL %s #%0d: got sel=%0d enb=%0b last=%0b, expected sel=%0d enb=%0b last=%0b", tname, checks, selector, selector_enb, burst_last, e.sel, e.enb, e.last);
            else passes++;
        end
        enb = 1'b0;
        push_idle(2, 2);
        while (sb.size() > 0) begin
            tick(); e = sb.pop_front(); checks++;
            if ({selector, selector_enb, burst_last} !== {e.sel, e.enb, e.last})
                $display("FAIL %s #%0d: got sel=%0d enb=%0b last=%0b, expected sel=%0d enb=%0b last=%0b", tname, checks, selector, selector_enb, burst_last, e.sel, e.enb, e.last);
            else passes++;
        end
        enb = 1'b1;
        push_run(2, 2); push_run(3, 6); push_run(0, 1);
        while (sb.size() > 0) begin
            tick(); e = sb.pop_front(); checks++;
            if ({selector, selector_enb, burst_last} !== {e.sel, e.enb, e.last})
                $display("FAIL %s #%0d: got sel=%0d enb=%0b last=%0b, expected sel=%0d enb=%0b last=%0b", tname, checks, selector, selector_enb, burst_last, e.sel, e.enb, e.last);
            else passes++;
        end
    endtask

    task automatic test_back_to_back();
        tname = "backpressure";
        push_run(1, 2); push_run(2, 3); push_grant(3, 1'b0); push_grant(3, 1'b0);
        while (sb.size() > 0) begin
            tick(); e = sb.pop_front(); checks++;
            if ({selector, selector_enb, burst_last} !== {e.sel, e.enb, e.last})
                $display("FAIL %s #%0d: got sel=%0d enb=%0b last=%0b, expected sel=%0d enb=%0b last=%0b", tname, checks, selector, selector_enb, burst_last, e.sel, e.enb, e.last);
            else passes++;
        end
        dest_full = 1'b1;
        push_idle(3, 3);
        while (sb.size() > 0) begin
            tick(); e = sb.pop_front(); checks++;
            if ({selector, selector_enb, burst_last} !== {e.sel, e.enb, e.last})
                $display("FAIL %s #%0d: got sel=%0d enb=%0b last=%0b, expected sel=%0d enb=%0b last=%0b", tname, checks, selector, selector_enb, burst_last, e.sel, e.enb, e.last);
            else passes++;
        end
        dest_full = 1'b0;
        push_run(3, 4); push_run(0, 1);
        while (sb.size() > 0) begin
            tick(); e = sb.pop_front(); checks++;
            if ({selector, selector_enb, burst_last} !== {e.sel, e.enb, e.last})
                $display("FAIL %s #%0d: got sel=%0d enb=%0b last=%0b, expected sel=%0d enb=%0b last=%0b", tname, checks, selector, selector_enb, burst_last, e.sel, e.enb, e.last);
            else passes++;
        end
    endtask

    task automatic test_priority();
        tname = "priority";
        mode = 1'b1;
        buf_empty = 4'b0001;
        for (int i = 0; i < 3; i++) push_grant(1, 1'b1);
        while (sb.size() > 0) begin
            tick(); e = sb.pop_front(); checks++;
            if ({selector, selector_enb, burst_last} !== {e.sel, e.enb, e.last})
                $display("FAIL %s #%0d: got sel=%0d enb=%0b last=%0b, expected sel=%0d enb=%0b last=%0b", tname, checks, selector, selector_enb, burst_last, e.sel, e.enb, e.last);
            else passes++;
        end
        buf_empty = 4'b1111;
        push_idle(1, 2);
        while (sb.size() > 0) begin
            tick(); e = sb.pop_front(); checks++;
            if ({selector, selector_enb, burst_last} !== {e.sel, e.enb, e.last})
                $display("FAIL %s #%0d: got sel=%0d enb=%0b last=%0b, expected sel=%0d enb=%0b last=%0b", tname, checks, selector, selector_enb, burst_last, e.sel, e.enb, e.last);
            else passes++;
        end
        mode = 1'b0;
        buf_empty = 4'b0000;
        push_run(2, 3); push_run(3, 6); push_run(0, 1); push_run(1, 2);
        while (sb.size() > 0) begin
            tick(); e = sb.pop_front(); checks++;
            if ({selector, selector_enb, burst_last} !== {e.sel, e.enb, e.last})
                $display("FAIL %s #%0d: got sel=%0d enb=%0b last=%0b, expected sel=%0d enb=%0b last=%0b", tname, checks, selector, selector_enb, burst_last, e.sel, e.enb, e.last);
            else passes++;
        end
    endtask

    task automatic test_reset_mid_burst();
        tname = "reset_mid_burst";
        push_run(2, 3); push_grant(3, 1'b0); push_grant(3, 1'b0);
        while (sb.size() > 0) begin
            tick(); e = sb.pop_front(); checks++;
            if ({selector, selector_enb, burst_last} !== {e.sel, e.enb, e.last})
                $display("FAIL %s #%0d: got sel=%0d enb=%0b last=%0b, expected sel=%0d enb=%0b last=%0b", tname, checks, selector, selector_enb, burst_last, e.sel, e.enb, e.last);
            else passes++;
        end
        rst = 1'b1;
        push_idle(0, 1);
        while (sb.size() > 0) begin
            tick(); e = sb.pop_front(); checks++;
            if ({selector, selector_enb, burst_last} !== {e.sel, e.enb, e.last})
                $display("FAIL %s #%0d: got sel=%0d enb=%0b last=%0b, expected sel=%0d enb=%0b last=%0b", tname, checks, selector, selector_enb, burst_last, e.sel, e.enb, e.last);
            else passes++;
        end
        rst = 1'b0;
        push_run(1, 2); push_run(2, 3);
        while (sb.size() > 0) begin
            tick(); e = sb.pop_front(); checks++;
            if ({selector, selector_enb, burst_last} !== {e.sel, e.enb, e.last})
                $display("FAIL %s #%0d: got sel=%0d enb=%0b last=%0b, expected sel=%0d enb=%0b last=%0b", tname, checks, selector, selector_enb, burst_last, e.sel, e.enb, e.last);
            else passes++;
        end
    endtask

    initial begin
        test_reset();
        test_weighted();
        test_zero_weight();
        test_occupancy();
        test_enable_hold();
        test_back_to_back();
        test_priority();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/round_robin_ponderado_param.md
# round_robin_ponderado_param

Parametrised weighted round-robin arbiter; successor to the fixed 4-queue weighted arbiter. Sits between the per-class input FIFOs and the shared output mux, selecting which FIFO is popped each cycle. Adds run-time weights of configurable width, occupancy-limited bursts, downstream backpressure, a strict-priority mode and an end-of-burst flag.

## Interface
- QUEUE_QUANTITY, 4: number of queues; ≥2.
- MAX_WEIGHT, 64: weight range; WB = $clog2(MAX_WEIGHT) bits per weight, max weight MAX_WEIGHT-1.
- BUF_WIDTH, 3: FIFO address width; per-queue occupancy field is CW = BUF_WIDTH+1 bits (0..2^BUF_WIDTH).
- SB = $clog2(QUEUE_QUANTITY) (derived).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- enb  in  1  block enable.
- mode  in  1  0 = weighted round-robin, 1 = strict priority (lowest index wins).
- pesos  in  QUEUE_QUANTITY*WB  weight of queue i at [i*WB +: WB].
- buf_empty  in  QUEUE_QUANTITY  1 = FIFO i empty.
- fifo_counter  in  QUEUE_QUANTITY*CW  occupancy of FIFO i at [i*CW +: CW].
- dest_full  in  1  downstream cannot accept; stalls arbitration.
- selector  out  SB  granted queue index (registered).
- selector_enb  out  1  grant valid; pop FIFO `selector` this cycle (registered).
- burst_last  out  1  grant consumes the last credit of the current burst (registered; only with selector_enb).

## Operation
- eligible[i] = !buf_empty[i] && pesos[i] != 0. Zero-weight queues are never granted in either mode.
- Internal state: cur (SB bits, current queue), credit (WB bits, grants remaining in current burst after the one just issued).
- burst load L[j] = min(pesos[j], max(fifo_counter[j],1)).
- Reset (rst=1): cur=0, credit=0, selector=0, selector_enb=0, burst_last=0. Overrides enb/dest_full.
- enb=0 or dest_full=1: selector_enb<=0, burst_last<=0; cur, credit, selector hold. Burst resumes with remaining credit.
- Weighted mode (mode=0), enb=1, dest_full=0:
  - HOLD: credit>0 and eligible[cur] → grant cur; credit<=credit-1; burst_last<=(credit==1).
  - SWITCH: otherwise search circularly cur+1, cur+2, …, cur (cur last, indices mod QUEUE_QUANTITY); first eligible j → cur<=j, grant j, credit<=L[j]-1, burst_last<=(L[j]==1).
  - IDLE: no eligible queue → selector_enb<=0, burst_last<=0, credit<=0, cur holds.
  - Queue emptying mid-burst forfeits remaining credit (no carry-over).
- Priority mode (mode=1): grant lowest-index eligible j; cur<=j, credit<=0, burst_last<=1. None eligible → selector_enb<=0.
- mode is sampled every cycle; switching 1→0 starts from a SWITCH search at cur+1; switching 0→1 discards credit.
- Grant = selector<=j, selector_enb<=1.

## Timing
- One-cycle latency: inputs sampled at edge N determine outputs valid after edge N. No combinational path input→output.
- First possible grant: edge following the first cycle with rst=0.
- Upstream must present buf_empty/fifo_counter reflecting pops granted in the previous cycle; the arbiter does not track its own pops.
- Sustained throughput: one grant per cycle while any queue eligible and dest_full=0, including at burst boundaries (no bubble on switch).
- Wrap-around: search from QUEUE_QUANTITY-1 continues at 0.
- Reset mid-burst: next cycle outputs at reset values; burst lost; post-reset search starts at queue 1.

## Test plan
- QUEUE_QUANTITY=4, pesos {q3..q0}={6,3,2,1}, all counts 8, none empty, mode=0 → after reset grant sequence q1×2, q2×3, q3×6, q0×1, repeating; burst_last high on last grant of each run.
- Same, pesos[q1]=0 → q1 never selected; sequence q2×3, q3×6, q0×1.
- fifo_counter[q2]=1 (others 8) → q2 burst length 1 with burst_last=1, then q3.
- dest_full high for 3 cycles during 2nd grant of q3 → selector_enb=0 for 3 cycles, selector held at 3; then remaining 4 grants of q3.
- mode=1, buf_empty=4'b0001 → selector=1 every cycle, burst_last=1; buf_empty=4'b1111 → selector_enb=0; return to mode=0 → search resumes from cur+1.
- rst pulsed during q3 burst → next cycle selector=0, selector_enb=0; after release first grant is q1×2.
